// File: rtl/direction_queue.sv
// direction_queue: FIFO of player headings between key pulses and the snake step engine.
// Latency: a press shows in pending/full/rejected one cycle later; a step updates dir one cycle later.
// Backpressure: none upstream; presses arriving on a full queue without a step are dropped with rejected.
// Optional DIRQ_REVERSE_FILTER_EN also drops presses opposite to the reference heading.
module direction_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_press,
    input  logic          down_press,
    input  logic          left_press,
    input  logic          right_press,
    input  logic          step,
    input  logic [1:0]    game_status,
    output logic [1:0]    dir,
    output logic [CW-1:0] pending,
    output logic          full,
    output logic          rejected
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_RESTART = 2'b00;
    localparam logic [1:0] ST_PLAY    = 2'b10;
    localparam logic [1:0] DIR_RIGHT  = 2'b11;

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic          in_play;
    logic          any_press;
    logic          multi_press;
    logic [1:0]    cand;
    logic [1:0]    ref_dir;
    logic          is_dup;
    logic          is_opp;
    logic          push;
    logic          pop;
    logic          reject_nxt;
    logic [CW-1:0] pending_nxt;

    assign in_play   = (game_status == ST_PLAY);
    assign any_press = up_press | down_press | left_press | right_press;
    assign multi_press = (up_press & (down_press | left_press | right_press)) |
                         (down_press & (left_press | right_press)) |
                         (left_press & right_press);

    always_comb begin
        cand = DIR_RIGHT;
        if (up_press)
            cand = 2'b00;
        else if (down_press)
            cand = 2'b01;
        else if (left_press)
            cand = 2'b10;
    end

    // The tail still counts as the reference even if it is being popped this cycle.
    assign ref_dir = (pending != '0) ? mem[wr_ptr - AW'(1)] : dir;
    assign is_dup  = (cand == ref_dir);

`ifdef DIRQ_REVERSE_FILTER_EN
    // Opposite pairs differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
    assign is_opp = (cand == (ref_dir ^ 2'b01));
`else
    assign is_opp = 1'b0;
`endif

    assign push = in_play && any_press && !is_dup && !is_opp && (!full || step);
    assign pop  = in_play && step && (pending != '0);

    assign reject_nxt = multi_press ||
                        (any_press && !is_dup && is_opp) ||
                        (any_press && !is_dup && !is_opp && full && !step);

    always_comb begin
        pending_nxt = pending;
        if (push && !pop)
            pending_nxt = pending + CW'(1);
        else if (pop && !push)
            pending_nxt = pending - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= cand;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir      <= DIR_RIGHT;
            pending  <= '0;
            full     <= 1'b0;
            rejected <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (!in_play) begin
            pending  <= '0;
            full     <= 1'b0;
            rejected <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            if (game_status == ST_RESTART)
                dir <= DIR_RIGHT;
        end else begin
            rejected <= reject_nxt;
            pending  <= pending_nxt;
            full     <= (pending_nxt == CW'(DEPTH));
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                dir    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

endmodule
